// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   32 x 32-bit general-purpose register file for the single-cycle CPU.
//   Register 0 is hardwired to zero. Two combinational read ports feed the
//   datapath (rs, rt). A third combinational read port serves the board
//   display. One write port is captured on the rising clock edge.
//
// Ports
//   CLK        in   system clock; writes capture on the rising edge
//   RST        in   asynchronous active-low reset; clears every register
//   RegWre     in   write enable
//   ReadReg1   in   read port 1 index (rs)
//   ReadReg2   in   read port 2 index (rt)
//   WriteReg   in   write port index
//   WriteData  in   write data
//   ReadData1  out  reg[ReadReg1]
//   ReadData2  out  reg[ReadReg2]
//   DbgAddr    in   debug read index
//   DbgData    out  reg[DbgAddr]
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RegWre,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [ADDR_WIDTH-1:0] DbgAddr,
  output logic [DATA_WIDTH-1:0] DbgData
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_reg [DEPTH];
  logic [DEPTH-1:0]      we_vec;

  // Per-register write enables. Entry 0 is tied to a constant 0 so that an
  // unknown RegWre or WriteReg can never reach register 0.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      if (gi == 0) begin : g_zero
        assign we_vec[gi] = 1'b0;
      end else begin : g_reg
        assign we_vec[gi] = RegWre && (WriteReg == ADDR_WIDTH'(gi));
      end
    end
  endgenerate

  // Storage. The asynchronous reset has priority, so a write whose edge
  // falls while RST is low is discarded. Entry 0 is cleared on reset and
  // never written afterwards.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (we_vec[i]) begin
          rf_reg[i] <= WriteData;
        end
      end
    end
  end

  // Combinational reads with no write bypass. A same-index read returns the
  // old value before the edge and the new value after it. The single-cycle
  // datapath depends on this behaviour. Index 0 and the reset state are
  // forced to zero at the output as well.
  function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (RST && (addr != '0)) begin
      val = rf_reg[addr];
    end
    return val;
  endfunction

  assign ReadData1 = rd(ReadReg1);
  assign ReadData2 = rd(ReadReg2);
  assign DbgData   = rd(DbgAddr);

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Directed test of register_file. A behavioural array model holds the
//   architectural register contents. It is cleared whenever reset falls and
//   is updated on each rising edge for enabled, non-zero writes outside
//   reset. A compare process checks all three read ports against the model
//   on every falling edge. Directed steps add literal checks.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        CLK;
  logic        RST;
  logic        RegWre;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  DbgAddr;
  logic [31:0] DbgData;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RegWre    (RegWre),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .DbgAddr   (DbgAddr),
    .DbgData   (DbgData)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: the register contents follow the architectural rules directly.
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end

  always @(negedge RST) begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end

  always @(posedge CLK) begin
    if (RST === 1'b1 && RegWre === 1'b1 && WriteReg != 5'd0) begin
      model[WriteReg] = WriteData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("cyc_rd1", ReadData1, model[ReadReg1]);
    chk("cyc_rd2", ReadData2, model[ReadReg2]);
    chk("cyc_dbg", DbgData,   model[DbgAddr]);
  end

  // Advance past the next rising edge; returns 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_write(input logic we, input logic [4:0] wr, input logic [31:0] wd);
    RegWre    = we;
    WriteReg  = wr;
    WriteData = wd;
    $display("[TB] t=%0t we=%0b wr=%0d wd=%h rst=%0b", $time, we, wr, wd, RST);
  endtask

  initial begin
    RST = 1'b0; RegWre = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    WriteReg = 5'd0; WriteData = 32'h0; DbgAddr = 5'd0;

    // Reset state
    #1;
    chk("reset_rd1", ReadData1, 32'h0);
    chk("reset_rd2", ReadData2, 32'h0);
    chk("reset_dbg", DbgData,   32'h0);
    #12 RST = 1'b1;
    step();

    // 1. Reset clear, with a mid-cycle reset pulse
    set_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    ReadReg1 = 5'd5;
    step();
    chk("t1_written", ReadData1, 32'hDEAD_BEEF);
    set_write(1'b0, 5'd5, 32'h0);
    #3 RST = 1'b0;
    #1 chk("t1_rst_fall", ReadData1, 32'h0);
    #2 RST = 1'b1;
    #1 chk("t1_rst_rise", ReadData1, 32'h0);
    step();
    chk("t1_after", ReadData1, 32'h0);

    // 2. Basic write/read, then hold with the write enable low
    set_write(1'b1, 5'd8, 32'h1234_5678);
    step();
    ReadReg1 = 5'd8; ReadReg2 = 5'd9;
    #1;
    chk("t2_rd1", ReadData1, 32'h1234_5678);
    chk("t2_rd2", ReadData2, 32'h0);
    set_write(1'b0, 5'd8, 32'hFFFF_FFFF);
    repeat (3) step();
    chk("t2_hold", ReadData1, 32'h1234_5678);

    // 3. Register zero ignores writes
    set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    set_write(1'b0, 5'd0, 32'h0);
    ReadReg1 = 5'd0; ReadReg2 = 5'd0; DbgAddr = 5'd0;
    #1;
    chk("t3_rd1", ReadData1, 32'h0);
    chk("t3_rd2", ReadData2, 32'h0);
    chk("t3_dbg", DbgData,   32'h0);

    // 4. Same-cycle read/write: old value before the edge, new value after
    set_write(1'b1, 5'd3, 32'h0000_0011);
    step();
    WriteData = 32'h0000_0022;
    ReadReg1 = 5'd3;
    #1 chk("t4_before", ReadData1, 32'h0000_0011);
    step();
    chk("t4_after", ReadData1, 32'h0000_0022);
    set_write(1'b0, 5'd0, 32'h0);

    // 5. Full sweep
    for (int i = 1; i < 32; i++) begin
      set_write(1'b1, 5'(i), 32'hA5A5_0000 + 32'(i));
      step();
    end
    set_write(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e;
      e = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
      ReadReg1 = 5'(i); ReadReg2 = 5'(i); DbgAddr = 5'(i);
      #1;
      chk("t5_rd1", ReadData1, e);
      chk("t5_rd2", ReadData2, e);
      chk("t5_dbg", DbgData,   e);
    end
    ReadReg1 = 5'd31; ReadReg2 = 5'd1;
    #1;
    chk("t5_pair1", ReadData1, 32'hA5A5_001F);
    chk("t5_pair2", ReadData2, 32'hA5A5_0001);
    step();

    // 6. Writes during reset are discarded
    RST = 1'b0;
    set_write(1'b1, 5'd7, 32'h5555_5555);
    repeat (2) step();
    set_write(1'b0, 5'd0, 32'h0);
    RST = 1'b1;
    ReadReg2 = 5'd7;
    #1 chk("t6_rd2", ReadData2, 32'h0);
    repeat (2) step();
    chk("t6_rd2_later", ReadData2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle CPU.
- Feeds the datapath 32-bit 2:1 multiplexers:
  - ReadData2 drives the in0 leg of the ALU-B select mux; the immediate drives in1.
  - The write-data mux (ALU result vs memory data) drives WriteData back into this block.
- Two combinational read ports, one synchronous write port, one combinational debug read port for the board display.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32.

Ports:
- CLK  input  1  system clock; writes occur on rising edge.
- RST  input  1  asynchronous, active-low reset; 0 clears all registers.
- RegWre  input  1  write enable; 1 = write WriteData into WriteReg at the next rising CLK.
- ReadReg1  input  ADDR_WIDTH  index for read port 1 (rs).
- ReadReg2  input  ADDR_WIDTH  index for read port 2 (rt).
- WriteReg  input  ADDR_WIDTH  index for the write port (rd/rt, chosen upstream).
- WriteData  input  DATA_WIDTH  data to write.
- ReadData1  output  DATA_WIDTH  contents of register ReadReg1.
- ReadData2  output  DATA_WIDTH  contents of register ReadReg2.
- DbgAddr  input  ADDR_WIDTH  index for the debug read port.
- DbgData  output  DATA_WIDTH  contents of register DbgAddr.

Behaviour:
- Storage: array of 2**ADDR_WIDTH registers, each DATA_WIDTH bits. Register 0 is hardwired to 0.
- Reset:
  - RST low clears all registers to 32'h0000_0000 immediately, independent of CLK.
  - While RST is low: all read outputs = 0 and writes are blocked.
- Reset mid-operation: a write whose rising edge coincides with RST low is discarded.
- Write:
  - On rising CLK with RST high and RegWre = 1: reg[WriteReg] <= WriteData.
  - If WriteReg = 0, the write is ignored and reg[0] stays 0.
  - RegWre = 0: no register changes.
- Read:
  - Purely combinational, no clock latency.
  - ReadData1 = reg[ReadReg1]; ReadData2 = reg[ReadReg2]; DbgData = reg[DbgAddr].
  - Reading index 0 always returns 0.
- Read/write same index, same cycle:
  - No internal bypass.
  - Before the edge, reads return the old value; after the edge, reads return the new value within the same combinational settle time.
  - The single-cycle datapath relies on this. A bypass must not be added.
- Multiple ports addressing the same register: all return identical data.
- Write latency: 1 edge. Data is visible on read ports immediately after the capturing rising edge.
- X-safety: RegWre = X or WriteReg = X must never corrupt reg[0]. The guard on index 0 is applied to the write-enable, not only at the output.
- Widths: all indices are unsigned. With default parameters there are no out-of-range indices.
- Implementation budget: roughly 120-200 lines, including the debug port and parameterised generate/loop reset.

Test Plan:
1. Reset clear:
   - Write 32'hDEAD_BEEF to r5, then pulse RST low mid-cycle (not on a CLK edge).
   - ReadReg1 = 5 -> ReadData1 = 0 immediately on RST fall; stays 0 after RST rises.
2. Basic write/read:
   - RegWre = 1, WriteReg = 8, WriteData = 32'h1234_5678, one rising edge.
   - ReadReg1 = 8 -> 32'h1234_5678; ReadReg2 = 9 -> 0.
   - Set RegWre = 0 with WriteData = 32'hFFFF_FFFF for 3 edges -> r8 unchanged.
3. Register zero:
   - RegWre = 1, WriteReg = 0, WriteData = 32'hFFFF_FFFF, edge.
   - ReadReg1 = 0, ReadReg2 = 0, DbgAddr = 0 -> all 0.
4. Same-cycle read/write:
   - r3 = 32'h0000_0011; set ReadReg1 = 3, WriteReg = 3, WriteData = 32'h0000_0022, RegWre = 1.
   - ReadData1 = 32'h11 before the edge, 32'h22 after the edge.
5. Full sweep:
   - Write r[i] = 32'hA5A5_0000 + i for i = 1..31.
   - Read all 32 indices on both ports and on DbgAddr.
   - r0 = 0; r[i] matches on all three outputs; ReadReg1 = 31 and ReadReg2 = 1 together give 32'hA5A5_001F and 32'hA5A5_0001.
6. Write during reset:
   - Hold RST low, RegWre = 1, WriteReg = 7, WriteData = 32'h5555_5555, 2 edges; release RST.
   - ReadReg2 = 7 -> 0.
